// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if
// Purpose : word-access memory bus between the MEM-stage access controller
//           and the data memory.
// Signals : MemReq   - access request, held until MemAck or timeout
//           MemWe    - 1 = store, 0 = load (valid while MemReq=1)
//           MemAddr  - byte address (word aligned)
//           MemWData - store data
//           MemAck   - single-cycle completion strobe from memory
//           MemRData - load data, valid when MemAck=1
// Modports: master - the controller side; slave - the memory side.
interface mem_access_ctrl_if;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic        MemAck;
  logic [31:0] MemRData;

  modport master (
    output MemReq, MemWe, MemAddr, MemWData,
    input  MemAck, MemRData
  );

  modport slave (
    input  MemReq, MemWe, MemAddr, MemWData,
    output MemAck, MemRData
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
// Purpose : MEM-stage memory access sequencer. Turns a word load/store from
//           the pipeline into a request on the memory bus, waits up to
//           TIMEOUT cycles for the ack, stalls the pipeline while busy and
//           latches sticky halt/error conditions.
// Ports   : CLK, RSTn            - clock, async active-low reset
//           LoadM, MemWriteM     - load / store in MEM (both = store)
//           ALUOutM, WriteDataM  - byte address, store data
//           StopM                - halt instruction in MEM
//           mem (master)         - memory bus (request out, ack/data in)
//           ReadDataM            - registered load result
//           StallM               - combinational pipeline freeze (up to EX/MEM)
//           ErrM, HaltDone       - sticky error / halt flags
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for a load/store or halt in MEM
// ACCESS | request outstanding, counting cycles without MemAck
// DONE   | one-cycle completion slot, pipeline released
// HALT   | halted, left only by reset
// ERROR  | misaligned address or timeout, left only by reset
module mem_access_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     LoadM,
  input  logic                     MemWriteM,
  input  logic [31:0]              ALUOutM,
  input  logic [31:0]              WriteDataM,
  input  logic                     StopM,
  mem_access_ctrl_if.master        mem,
  output logic [31:0]              ReadDataM,
  output logic                     StallM,
  output logic                     ErrM,
  output logic                     HaltDone
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCESS = 3'd1,
    DONE   = 3'd2,
    HALT   = 3'd3,
    ERROR  = 3'd4
  } state_t;

  localparam logic [7:0] LastCount = 8'(TIMEOUT - 1);

  state_t     state;
  logic [7:0] count;
  logic       accessReq;

  assign accessReq = LoadM | MemWriteM;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state        <= IDLE;
      count        <= '0;
      mem.MemReq   <= 1'b0;
      mem.MemWe    <= 1'b0;
      mem.MemAddr  <= '0;
      mem.MemWData <= '0;
      ReadDataM    <= '0;
      ErrM         <= 1'b0;
      HaltDone     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accessReq) begin
            if (ALUOutM[1:0] != 2'b00) begin
              state <= ERROR;
              ErrM  <= 1'b1;
            end else begin
              // A simultaneous load+store is issued as a store.
              state        <= ACCESS;
              mem.MemAddr  <= ALUOutM;
              mem.MemWData <= WriteDataM;
              mem.MemWe    <= MemWriteM;
              mem.MemReq   <= 1'b1;
              count        <= '0;
            end
          end else if (StopM) begin
            state    <= HALT;
            HaltDone <= 1'b1;
          end
        end
        ACCESS: begin
          // Ack is checked first so it wins over a same-cycle timeout.
          if (mem.MemAck) begin
            state      <= DONE;
            mem.MemReq <= 1'b0;
            mem.MemWe  <= 1'b0;
            if (!mem.MemWe) begin
              ReadDataM <= mem.MemRData;
            end
          end else if (count == LastCount) begin
            state      <= ERROR;
            mem.MemReq <= 1'b0;
            mem.MemWe  <= 1'b0;
            ErrM       <= 1'b1;
          end else begin
            count <= count + 8'd1;
          end
        end
        DONE: begin
          if (StopM) begin
            state    <= HALT;
            HaltDone <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        HALT:    state <= HALT;
        ERROR:   state <= ERROR;
        default: state <= IDLE;
      endcase
    end
  end

  // DONE releases the pipeline so the completed instruction leaves MEM.
  always_comb begin
    StallM = 1'b0;
    case (state)
      IDLE:    StallM = accessReq | StopM;
      ACCESS:  StallM = 1'b1;
      DONE:    StallM = 1'b0;
      HALT:    StallM = 1'b1;
      ERROR:   StallM = 1'b1;
      default: StallM = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl
// Purpose : randomized self-checking bench for mem_access_ctrl. Each
//           transaction is described by its kind, address, data and the
//           ACCESS cycle on which memory acks; the expected bus/flag
//           behaviour is derived from that description.
module tb_mem_access_ctrl;
  localparam int TIMEOUT = 16;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        LoadM, MemWriteM, StopM;
  logic [31:0] ALUOutM, WriteDataM, ReadDataM;
  logic        StallM, ErrM, HaltDone;

  mem_access_ctrl_if mem ();

  mem_access_ctrl #(.TIMEOUT(TIMEOUT)) dut (
    .CLK        (CLK),
    .RSTn       (RSTn),
    .LoadM      (LoadM),
    .MemWriteM  (MemWriteM),
    .ALUOutM    (ALUOutM),
    .WriteDataM (WriteDataM),
    .StopM      (StopM),
    .mem        (mem),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .ErrM       (ErrM),
    .HaltDone   (HaltDone)
  );

  always #5 CLK = ~CLK;

  int nChecks = 0;
  int nFails  = 0;

  // Reference model state: what the registered outputs must hold.
  logic [31:0] expAddr, expWData, expRead;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nFails++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // All tasks start and end at 1 time unit after a rising edge.
  task automatic nextCycle();
    @(posedge CLK);
    #1;
  endtask

  task automatic setIdleInputs();
    LoadM        = 1'b0;
    MemWriteM    = 1'b0;
    StopM        = 1'b0;
    ALUOutM      = $urandom;
    WriteDataM   = $urandom;
    mem.MemAck   = 1'($urandom_range(0, 1));
    mem.MemRData = $urandom;
  endtask

  task automatic doReset();
    RSTn = 1'b0;
    #1;
    checkVal("rst_req",    32'(mem.MemReq), 0);
    checkVal("rst_we",     32'(mem.MemWe), 0);
    checkVal("rst_addr",   mem.MemAddr, 0);
    checkVal("rst_wdata",  mem.MemWData, 0);
    checkVal("rst_rdata",  ReadDataM, 0);
    checkVal("rst_err",    32'(ErrM), 0);
    checkVal("rst_halt",   32'(HaltDone), 0);
    expAddr  = '0;
    expWData = '0;
    expRead  = '0;
    setIdleInputs();
    @(negedge CLK);
    RSTn = 1'b1;
    nextCycle();
  endtask

  task automatic idleGap(input int n);
    for (int i = 0; i < n; i++) begin
      setIdleInputs();
      #1;
      checkVal("idle_stall", 32'(StallM), 0);
      checkVal("idle_req",   32'(mem.MemReq), 0);
      checkVal("idle_addr",  mem.MemAddr, expAddr);
      checkVal("idle_wdata", mem.MemWData, expWData);
      checkVal("idle_rdata", ReadDataM, expRead);
      nextCycle();
    end
  endtask

  // Terminal states: random pipeline/bus activity must change nothing.
  task automatic holdTerminal(input bit isErr, input int n);
    for (int i = 0; i < n; i++) begin
      LoadM        = 1'($urandom_range(0, 1));
      MemWriteM    = 1'($urandom_range(0, 1));
      StopM        = 1'($urandom_range(0, 1));
      ALUOutM      = $urandom;
      mem.MemAck   = 1'($urandom_range(0, 1));
      mem.MemRData = $urandom;
      #1;
      checkVal("term_stall", 32'(StallM), 1);
      checkVal("term_req",   32'(mem.MemReq), 0);
      checkVal("term_err",   32'(ErrM), 32'(isErr));
      checkVal("term_halt",  32'(HaltDone), 32'(!isErr));
      checkVal("term_rdata", ReadDataM, expRead);
      nextCycle();
    end
  endtask

  // One load/store. ackAt = ACCESS cycle index carrying MemAck (>= TIMEOUT
  // means never). Returns terminal=1 when the block ended in HALT/ERROR.
  task automatic doAccess(input bit ld, input bit st, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] rdata,
                          input int ackAt, input bit stop, output bit terminal);
    LoadM        = ld;
    MemWriteM    = st;
    ALUOutM      = addr;
    WriteDataM   = wdata;
    StopM        = stop;
    mem.MemAck   = 1'($urandom_range(0, 1));
    mem.MemRData = $urandom;
    #1;
    checkVal("req_stall", 32'(StallM), 1);
    nextCycle();
    if (addr[1:0] != 2'b00) begin
      mem.MemAck = 1'b0;
      #1;
      checkVal("misalign_err", 32'(ErrM), 1);
      checkVal("misalign_req", 32'(mem.MemReq), 0);
      holdTerminal(1'b1, 2);
      terminal = 1'b1;
      return;
    end
    for (int j = 0; j < TIMEOUT; j++) begin
      mem.MemAck   = (j == ackAt);
      mem.MemRData = (j == ackAt) ? rdata : $urandom;
      #1;
      checkVal("acc_req",   32'(mem.MemReq), 1);
      checkVal("acc_we",    32'(mem.MemWe), 32'(st));
      checkVal("acc_addr",  mem.MemAddr, addr);
      checkVal("acc_wdata", mem.MemWData, wdata);
      checkVal("acc_stall", 32'(StallM), 1);
      nextCycle();
      if (j == ackAt) break;
    end
    expAddr  = addr;
    expWData = wdata;
    if (ackAt < TIMEOUT) begin
      if (!st) expRead = rdata;
      LoadM        = 1'b0;
      MemWriteM    = 1'b0;
      mem.MemAck   = 1'($urandom_range(0, 1));
      mem.MemRData = $urandom;
      #1;
      checkVal("done_req",   32'(mem.MemReq), 0);
      checkVal("done_we",    32'(mem.MemWe), 0);
      checkVal("done_rdata", ReadDataM, expRead);
      checkVal("done_stall", 32'(StallM), 0);
      checkVal("done_err",   32'(ErrM), 0);
      nextCycle();
      if (stop) begin
        holdTerminal(1'b0, 3);
        terminal = 1'b1;
      end else begin
        terminal = 1'b0;
      end
    end else begin
      mem.MemAck = 1'b0;
      #1;
      checkVal("tmo_err",  32'(ErrM), 1);
      checkVal("tmo_req",  32'(mem.MemReq), 0);
      holdTerminal(1'b1, 2);
      terminal = 1'b1;
    end
  endtask

  task automatic doHalt();
    setIdleInputs();
    StopM = 1'b1;
    #1;
    checkVal("halt_req_stall", 32'(StallM), 1);
    nextCycle();
    holdTerminal(1'b0, 3);
  endtask

  task automatic resetMidAccess(input logic [31:0] addr, input int waitCycles);
    LoadM      = 1'b1;
    MemWriteM  = 1'b0;
    StopM      = 1'b0;
    ALUOutM    = addr;
    mem.MemAck = 1'b0;
    nextCycle();
    for (int i = 0; i < waitCycles; i++) nextCycle();
    checkVal("mid_req_before", 32'(mem.MemReq), 1);
    doReset();
  endtask

  function automatic logic [31:0] alignedAddr();
    logic [31:0] a;
    a = $urandom;
    a[1:0] = 2'b00;
    return a;
  endfunction

  initial begin
    bit          term;
    logic [31:0] a;
    int          kind;
    int          ack;

    setIdleInputs();
    doReset();

    doAccess(1'b1, 1'b0, 32'h100, $urandom, 32'hDEADBEEF, 1, 1'b0, term);
    idleGap(1);
    doAccess(1'b0, 1'b1, 32'h40, 32'h12345678, $urandom, 0, 1'b0, term);
    idleGap(1);
    doAccess(1'b1, 1'b1, 32'h80, $urandom, $urandom, 0, 1'b0, term);
    doAccess(1'b1, 1'b0, 32'h84, $urandom, $urandom, TIMEOUT - 1, 1'b0, term);
    doAccess(1'b1, 1'b0, 32'h200, $urandom, $urandom, TIMEOUT + 5, 1'b0, term);
    doReset();
    doAccess(1'b1, 1'b0, 32'h102, $urandom, $urandom, 0, 1'b0, term);
    doReset();
    doAccess(1'b0, 1'b1, 32'h44, $urandom, $urandom, 0, 1'b1, term);
    doReset();
    doHalt();
    doReset();
    resetMidAccess(32'h300, 2);
    doAccess(1'b1, 1'b0, 32'h300, $urandom, 32'hCAFEF00D, 0, 1'b0, term);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 19);
      a    = alignedAddr();
      ack  = ($urandom_range(0, 7) == 0) ? $urandom_range(0, TIMEOUT - 1)
                                          : $urandom_range(0, 4);
      term = 1'b0;
      case (kind)
        0: begin
          a[1:0] = 2'($urandom_range(1, 3));
          doAccess(1'($urandom_range(0, 1)), 1'b1, a, $urandom, $urandom, 0, 1'b0, term);
        end
        1: doAccess(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, $urandom,
                    $urandom, ack, 1'b1, term);
        2: doAccess(1'b1, 1'($urandom_range(0, 1)), a, $urandom, $urandom,
                    $urandom_range(TIMEOUT, TIMEOUT + 3), 1'b0, term);
        3: resetMidAccess(a, $urandom_range(0, 5));
        4: begin
          doHalt();
          term = 1'b1;
        end
        default: begin
          if ($urandom_range(0, 1) == 1)
            doAccess(1'b1, 1'($urandom_range(0, 1)), a, $urandom, $urandom, ack, 1'b0, term);
          else
            doAccess(1'b0, 1'b1, a, $urandom, $urandom, ack, 1'b0, term);
        end
      endcase
      if (term) doReset();
      idleGap($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the maximum number of ACCESS cycles waited for MemAck (legal range 2..255).
REQ-002 CLK  input  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-003 RSTn  input  1  SHALL be the reset, asynchronous and active-low.
REQ-004 LoadM  input  1  SHALL flag a word load in the MEM stage.
REQ-005 MemWriteM  input  1  SHALL flag a word store in the MEM stage.
REQ-006 ALUOutM  input  32  SHALL be the byte address of the access.
REQ-007 WriteDataM  input  32  SHALL be the store data.
REQ-008 StopM  input  1  SHALL flag a halt instruction in the MEM stage.
REQ-009 MemAck  input  1  SHALL be the memory completion strobe.
REQ-010 MemRData  input  32  SHALL be the memory read data, valid when MemAck=1.
REQ-011 MemReq  output  1  SHALL be the memory request, registered.
REQ-012 MemWe  output  1  SHALL be the memory write enable, registered.
REQ-013 MemAddr  output  32  SHALL be the memory address, registered.
REQ-014 MemWData  output  32  SHALL be the memory write data, registered.
REQ-015 ReadDataM  output  32  SHALL be the load result, registered.
REQ-016 StallM  output  1  SHALL freeze all pipeline registers up to and including EX/MEM when 1, combinational.
REQ-017 ErrM  output  1  SHALL be the sticky error flag, registered.
REQ-018 HaltDone  output  1  SHALL be the sticky halt flag, registered.

Function
REQ-019 The FSM SHALL have states IDLE, ACCESS, DONE, HALT and ERROR.
REQ-020 IDLE with LoadM|MemWriteM=1 and ALUOutM[1:0]=0 SHALL go to ACCESS and latch MemAddr=ALUOutM, MemWData=WriteDataM, MemWe=MemWriteM, MemReq=1, counter=0.
REQ-021 LoadM=1 and MemWriteM=1 together SHALL be treated as a store; ReadDataM is unchanged.
REQ-022 IDLE with an access and ALUOutM[1:0]!=0 SHALL go to ERROR with no MemReq issued.
REQ-023 IDLE with StopM=1 and no access SHALL go to HALT.
REQ-024 IDLE with no access and StopM=0 SHALL remain IDLE.
REQ-025 In ACCESS with MemAck=1, the FSM SHALL go to DONE, drop MemReq and MemWe, and load ReadDataM=MemRData when the access is a load.
REQ-026 In ACCESS with MemAck=0, the counter SHALL increment; if the counter equals TIMEOUT-1, the FSM SHALL go to ERROR and drop MemReq.
REQ-027 MemAck and the timeout in the same cycle: ack SHALL win.
REQ-028 DONE SHALL last exactly one cycle, then go to HALT if StopM=1, else IDLE.
REQ-029 MemAck outside ACCESS SHALL be ignored.
REQ-030 StallM SHALL be 1 in ACCESS, HALT and ERROR, and in IDLE when LoadM|MemWriteM|StopM=1; it SHALL be 0 in DONE and in idle IDLE.
REQ-031 Minimum access latency SHALL be 3 cycles (IDLE, ACCESS with immediate ack, DONE); back-to-back accesses SHALL each take at least 3 cycles.
REQ-032 HaltDone SHALL be 1 in HALT; ErrM SHALL be 1 in ERROR; both states SHALL be left only by reset.
REQ-033 MemAddr and MemWData SHALL hold their values after an access until the next access is latched.

Reset
REQ-034 RSTn=0 SHALL immediately force state=IDLE, counter=0 and MemReq, MemWe, MemAddr, MemWData, ReadDataM, ErrM, HaltDone=0, including during ACCESS.
REQ-035 After RSTn rises, the first posedge SHALL evaluate IDLE rules normally.

Verification
REQ-036 Load, ALUOutM=0x100, ack on the 2nd ACCESS cycle with MemRData=0xDEADBEEF -> MemReq high 2 cycles, ReadDataM=0xDEADBEEF, StallM=0 in the DONE cycle, total 4 cycles.
REQ-037 Store, ALUOutM=0x40, WriteDataM=0x12345678, immediate ack -> MemWe=1 and MemAddr=0x40 for 1 cycle, ReadDataM unchanged.
REQ-038 Load with no ack, TIMEOUT=16 -> MemReq drops after 16 ACCESS cycles, ErrM=1, StallM stays 1.
REQ-039 Load, ALUOutM=0x102 -> ERROR next cycle, MemReq never asserted.
REQ-040 Store with StopM=1 -> DONE then HALT, HaltDone=1, StallM=1 thereafter.
REQ-041 RSTn pulsed low mid-ACCESS -> MemReq=0 asynchronously; after release, a new load completes normally.
